// File: rtl/multdiv_iter_if.sv
// Handshake bundle for the iterative multiply/divide unit:
// operands and start pulses in, result, exception and ready pulse out.
interface multdiv_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes), one step per
// cycle through a single shared add/subtract, WIDTH steps, then a one-cycle DONE with ready.
module multdiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clock,
    input logic            resetn,
    multdiv_iter_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // One bit wider than the operands so Booth never overflows on the most negative multiplicand
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]   add_a, add_b, sum, booth_acc, prod_hi;
    logic             add_sub;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             start, last;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign last  = (cnt_q == CntW'(WIDTH));
    assign abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1))
                                              : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1))
                                              : bus.data_operandB;

    // Shared adder: Booth add/sub of the multiplicand, or trial subtract of the divisor
    always_comb begin
        add_a   = acc_q;
        add_b   = {mcand_q[WIDTH-1], mcand_q};
        add_sub = q_q[0] & ~qm1_q;
        if (state_q == StDiv) begin
            add_a   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
            add_b   = {1'b0, mcand_q};
            add_sub = 1'b1;
        end
    end

    assign sum     = add_a + (add_b ^ {(WIDTH + 1){add_sub}}) + (WIDTH + 1)'(add_sub);
    // Product bits [2*WIDTH-1 : WIDTH-1]; all equal means the product fits in WIDTH bits
    assign prod_hi = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        mcand_d   = mcand_q;
        qm1_d     = qm1_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        exc_d     = exc_q;
        booth_acc = (q_q[0] ^ qm1_q) ? sum : acc_q;

        unique case (state_q)
            StIdle: ;
            StMul: begin
                if (last) begin
                    result_d = q_q;
                    exc_d    = ~((&prod_hi) | ~(|prod_hi));
                    state_d  = StDone;
                end else begin
                    acc_d = {booth_acc[WIDTH], booth_acc[WIDTH:1]};
                    q_d   = {booth_acc[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDiv: begin
                if (last) begin
                    result_d = dz_q ? '0 : (neg_q ? (~q_q + WIDTH'(1)) : q_q);
                    exc_d    = dz_q | ovf_q;
                    state_d  = StDone;
                end else begin
                    // Negative trial difference restores the shifted remainder
                    if (!sum[WIDTH]) begin
                        acc_d = sum;
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = add_a;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d = bus.ctrl_MULT ? StMul : StDiv;
            cnt_d   = '0;
            acc_d   = '0;
            qm1_d   = 1'b0;
            if (bus.ctrl_MULT) begin
                mcand_d = bus.data_operandA;
                q_d     = bus.data_operandB;
            end else begin
                mcand_d = abs_b;
                q_d     = abs_a;
            end
            neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_d  = (bus.data_operandB == '0);
            ovf_d = (bus.data_operandA == {1'b1, {(WIDTH - 1){1'b0}}}) &&
                    (bus.data_operandB == '1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            mcand_q  <= '0;
            qm1_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            mcand_q  <= mcand_d;
            qm1_q    <= qm1_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == StDone);
endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: vector table plus abort/reset/operand-stability sequences,
// with a scoreboard queue popped whenever the ready pulse appears.
module tb_multdiv_iter;
    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    multdiv_iter_if #(.WIDTH(W)) bus ();
    multdiv_iter #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [W-1:0] r;
        logic         e;
        int           start;
    } exp_t;

    typedef struct {
        logic         mul;
        logic         div;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         e;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rdy_count = 0;
    logic prev_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1ns after each rising edge
    always @(posedge clock) begin
        exp_t x;
        cyc = cyc + 1;
        #1;
        if (bus.data_resultRDY === 1'b1) begin
            rdy_count++;
            check("rdy_width", {63'd0, prev_rdy}, 64'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: got ready with no pending op (cycle %0d)", cyc);
            end else begin
                x = sb.pop_front();
                check("result", {32'd0, bus.data_result}, {32'd0, x.r});
                check("exception", {63'd0, bus.data_exception}, {63'd0, x.e});
                check("latency", 64'(cyc - x.start), 64'(W + 1));
            end
        end
        prev_rdy = bus.data_resultRDY;
    end

    task automatic start_op(input logic mul, input logic div, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic push,
                            input logic [W-1:0] r, input logic e);
        exp_t x;
        @(negedge clock);
        bus.ctrl_MULT = mul;
        bus.ctrl_DIV = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        if (push) begin
            x.r = r;
            x.e = e;
            x.start = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (rdy_count == n && k < 80) begin
            @(posedge clock);
            #2;
            k++;
        end
        if (rdy_count == n) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no ready after %0d cycles, expected one", k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   n;

        vecs.push_back('{1, 0, -32'sd7, 32'sd6, 32'hFFFF_FFD6, 0});
        vecs.push_back('{1, 0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1});
        vecs.push_back('{1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1});
        vecs.push_back('{1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0});
        vecs.push_back('{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0});
        vecs.push_back('{1, 1, 32'd9, 32'd3, 32'd27, 0});
        vecs.push_back('{0, 1, -32'sd17, 32'sd5, 32'hFFFF_FFFD, 0});
        vecs.push_back('{0, 1, 32'sd100, -32'sd7, 32'hFFFF_FFF2, 0});
        vecs.push_back('{0, 1, 32'd123, 32'd0, 32'h0, 1});
        vecs.push_back('{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{0, 1, 32'h8000_0000, 32'd2, 32'hC000_0000, 0});
        vecs.push_back('{0, 1, 32'sd7, -32'sd7, 32'hFFFF_FFFF, 0});
        vecs.push_back('{0, 1, -32'sd5, 32'sd10, 32'h0, 0});

        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        check("reset_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
        check("reset_result", {32'd0, bus.data_result}, 64'd0);
        check("reset_exception", {63'd0, bus.data_exception}, 64'd0);

        foreach (vecs[i]) begin
            n = rdy_count;
            start_op(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r, vecs[i].e);
            wait_done(n);
            repeat (2) @(posedge clock);
        end

        // Divide aborted by a multiply 5 cycles later: only the multiply reports
        n = rdy_count;
        start_op(1'b0, 1'b1, 32'd50, 32'd7, 1'b0, '0, 1'b0);
        repeat (4) @(posedge clock);
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0);
        wait_done(n);
        repeat (10) @(posedge clock);
        #2;
        check("abort_single_rdy", 64'(rdy_count - n), 64'd1);

        // Operands change every cycle after the start edge
        n = rdy_count;
        start_op(1'b1, 1'b0, 32'sd1000, -32'sd1000, 1'b1, 32'hFFF0_BDC0, 1'b0);
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
        end
        wait_done(n);
        repeat (5) @(posedge clock);
        #2;
        check("hold_result", {32'd0, bus.data_result}, 64'hFFF0_BDC0);
        check("hold_exception", {63'd0, bus.data_exception}, 64'd0);

        // Reset 10 cycles into a multiply discards it
        n = rdy_count;
        start_op(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, '0, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        check("midreset_result", {32'd0, bus.data_result}, 64'd0);
        check("midreset_exception", {63'd0, bus.data_exception}, 64'd0);
        repeat (40) @(posedge clock);
        #2;
        check("midreset_no_rdy", 64'(rdy_count - n), 64'd0);

        n = rdy_count;
        start_op(1'b1, 1'b0, 32'h1234, -32'sd3, 1'b1, 32'hFFFF_C964, 1'b0);
        wait_done(n);
        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Iterative signed multiply/divide unit in the processor execute stage.
- Sits directly downstream of the carry-select adder chain. Each iteration's partial-product or partial-remainder update goes through one WIDTH-bit add/subtract built from that chain.
- Accepts a start pulse with two operands and returns one WIDTH-bit result after a fixed latency, with a ready pulse and an exception flag.

Parameters:
- WIDTH, 32: operand and result width. Iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- data_operandA  input  WIDTH  multiplicand or dividend, two's complement; sampled only on the start edge.
- data_operandB  input  WIDTH  multiplier or divisor, two's complement; sampled only on the start edge.
- ctrl_MULT  input  1  start-multiply pulse.
- ctrl_DIV  input  1  start-divide pulse.
- data_result  output  WIDTH  product (low WIDTH bits) or quotient.
- data_exception  output  1  overflow or divide-by-zero flag; valid when data_resultRDY is high.
- data_resultRDY  output  1  one-cycle pulse marking a new result.

Behaviour:
- Reset: resetn sampled low at a rising edge forces:
  - state IDLE
  - data_result = 0, data_exception = 0, data_resultRDY = 0
  - iteration counter = 0
  - any operation in flight is discarded.
- States: IDLE, MUL, DIV, DONE.
- Start:
  - At an edge with ctrl_MULT = 1: latch operands, clear the accumulator, counter = 0, go to MUL.
  - Otherwise, at an edge with ctrl_DIV = 1: same latch and clear, go to DIV.
  - Both high in the same cycle: MULT wins.
  - A start in any state, including MUL, DIV and DONE, aborts the current operation and restarts. No RDY pulse is produced for the aborted operation.
- MUL: radix-2 Booth, one step per cycle.
  - Each step adds, subtracts or does nothing with the multiplicand, based on the {Q0, Q-1} pair, then arithmetic-shifts right by 1.
  - Exactly WIDTH steps, then go to DONE.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, WIDTH steps, then go to DONE.
  - Quotient sign = sign(A) XOR sign(B); truncation is toward zero.
  - The remainder is internal only and is not output.
- DONE, held for one cycle:
  - Register data_result and data_exception.
  - data_resultRDY = 1 for exactly this one cycle.
  - Then go to IDLE.
- Latency: start sampled at edge E0. Steps occur at E1..E_WIDTH. Edge E_(WIDTH+1) registers the result and raises RDY. RDY is high during the cycle after E33 (WIDTH = 32) and low again after E34.
- Multiply exception: data_exception = 1 when the 2*WIDTH-bit signed product does not fit in WIDTH bits, i.e. its upper WIDTH+1 bits are not all equal. data_result is still the low WIDTH bits.
- Divide by zero (B = 0): data_exception = 1, data_result = 0, with normal latency.
- Divide overflow (A = -2^(WIDTH-1), B = -1): data_exception = 1, data_result = 0x80000000.
- Hold: data_result and data_exception hold their last values until the next DONE or reset. data_resultRDY is 0 in every state except DONE.
- Operands: changes on the operand inputs after the start edge have no effect.

Test Plan:
- Reset: resetn = 0 for 2 cycles mid-multiply (cycle 10 after start) -> result 0, exception 0, RDY never pulses. A fresh start afterwards completes normally.
- Signed multiply: ctrl_MULT with A = -7, B = 6 -> RDY high exactly in the cycle after E33; result 0xFFFFFFD6; exception 0. Repeat A = 0x7FFFFFFF, B = 2 -> result 0xFFFFFFFE, exception 1.
- Signed divide: ctrl_DIV with A = -17, B = 5 -> result 0xFFFFFFFD (-3), exception 0. A = 100, B = -7 -> result -14.
- Divide boundaries:
  - B = 0, A = 123 -> result 0, exception 1, RDY after 33 cycles.
  - A = 0x80000000, B = -1 -> result 0x80000000, exception 1.
- Abort and priority:
  - ctrl_DIV, then ctrl_MULT 5 cycles later with A = 3, B = 4 -> a single RDY pulse 33 cycles after the MULT start; result 12.
  - ctrl_MULT and ctrl_DIV asserted together with A = 9, B = 3 -> result 27.
- Operand stability: change A and B every cycle during the operation after starting MULT with A = 1000, B = -1000 -> result -1000000 (0xFFF0BDC0); RDY width exactly 1 cycle.
